muldiv: RTL and testbench
=========================

MULDIV -- requirements
Module: muldiv

Interface
REQ-001 Parameter N, default 32; operand and result width in bits; N is even and at least 8.
REQ-002 Port clk, input, 1: single clock; all state changes on the rising edge.
REQ-003 Port reset, input, 1: reset is synchronous and active-high.
REQ-004 Port start, input, 1: request a new operation; sampled only in IDLE.
REQ-005 Port op, input, 2: operation select: MULT=00, MULTU=01, DIV=10, DIVU=11.
REQ-006 Port A, input, N: multiplicand or dividend.
REQ-007 Port B, input, N: multiplier or divisor.
REQ-008 Port busy, output, 1: high while an accepted operation is in progress.
REQ-009 Port done, output, 1: one-cycle pulse; hi/lo hold the new result in that cycle.
REQ-010 Port hi, output, N: product upper half, or remainder.
REQ-011 Port lo, output, N: product lower half, or quotient.

Function
REQ-012 The FSM shall have the states IDLE, RUN and FIX.
REQ-013 IDLE -> RUN on a rising edge with start=1; op, A and B latched at that edge, later input changes ignored.
REQ-014 RUN shall perform one iteration per cycle for exactly N cycles (iteration counter 0..N-1) and then go to FIX.
REQ-015 FIX shall apply the sign correction, write hi/lo, and return to IDLE on the next edge.
REQ-016 Latency shall be fixed: start accepted at edge k -> done=1 in the cycle after edge k+N+2; hi/lo change only at that edge.
REQ-017 done shall be high for exactly one cycle, and a start in that same cycle shall be accepted.
REQ-018 busy shall be high from the edge that accepts start until the edge that writes hi/lo; busy and done are never high together.
REQ-019 start while busy=1 shall be ignored, with no effect on the operation in flight or on its result.
REQ-020 MULTU: {hi,lo} = A*B, unsigned 2N-bit product, computed by shift-add.
REQ-021 MULT: {hi,lo} = A*B, two's-complement 2N-bit product, computed on magnitudes and negated in FIX when sign(A) xor sign(B).
REQ-022 DIVU: lo = A/B and hi = A mod B, unsigned, computed by restoring division with an N+1-bit partial remainder.
REQ-023 DIV: quotient truncates toward zero; remainder takes the sign of the dividend; computed on magnitudes and corrected in FIX.
REQ-024 DIV and DIVU with B=0: lo = all ones, hi = A (as latched); latency unchanged.
REQ-025 DIV with A = most-negative and B = -1: lo = most-negative, hi = 0, with no trap or flag.
REQ-026 Magnitude of the most-negative value shall be handled as an unsigned N-bit 2^(N-1), with no overflow in the datapath.
REQ-027 hi/lo shall hold their last result indefinitely while IDLE.

Reset
REQ-028 reset=1 at an edge shall force: state IDLE, busy=0, done=0, hi=0, lo=0, iteration counter 0.
REQ-029 Reset during RUN or FIX shall abort the operation with no partial result visible, and the next start shall behave as from power-up.
REQ-030 reset shall take priority over start in the same cycle.

Structure
REQ-031 Package muldiv_pkg shall hold the op enum (MULT, MULTU, DIV, DIVU) and the FSM state enum.
REQ-032 The iteration counter width shall be $clog2(N)+1, defined as a localparam in muldiv.
REQ-033 There shall be no sub-module; the N+1-bit add/subtract step shall be inline in muldiv, and one shared adder shall serve both multiply and divide.
REQ-034 Outputs busy, done, hi and lo shall be driven directly from registers.

Verification
REQ-035 MULTU, A=0xFFFFFFFF, B=0xFFFFFFFF -> done exactly 34 cycles after the accepting edge, hi=0xFFFFFFFE, lo=0x00000001.
REQ-036 MULT, A=0xFFFFFFFD (-3), B=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
REQ-037 DIV, A=0xFFFFFFF9 (-7), B=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU A=100, B=0 -> lo=0xFFFFFFFF, hi=0x00000064.
REQ-038 DIV, A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0x00000000.
REQ-039 Start MULTU 6*7, pulse start with other operands at iteration 5 -> ignored, result hi=0, lo=42; back-to-back start in the done cycle accepted.
REQ-040 Start DIVU 1000/3, assert reset at iteration 10 -> next cycle busy=0, done=0, hi=lo=0; no done pulse follows.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } state_e;

    function automatic logic op_is_div(input op_e o);
        return o[1];
    endfunction

    function automatic logic op_is_signed(input op_e o);
        return ~o[0];
    endfunction

endpackage

// File: rtl/muldiv.sv
// Iterative N-bit multiply (shift-add) and divide (restoring) sharing one N+1-bit adder.
//
//   state | meaning
//   IDLE  | waiting for start; hi/lo hold the last result
//   RUN   | first cycle loads operand magnitudes, then N iteration cycles
//   FIX   | sign correction / divide-by-zero handling, write hi/lo, pulse done
module muldiv
    import muldiv_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo
);

    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST_IT = CW'(N - 1);

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           prep_q, prep_d;
    op_e            op_q, op_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic [N-1:0]   acc_q, acc_d;
    logic [N-1:0]   wrk_q, wrk_d;
    logic [N-1:0]   opb_q, opb_d;
    logic [N-1:0]   hi_q, hi_d;
    logic [N-1:0]   lo_q, lo_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic           is_div;
    logic           is_signed;
    logic [N-1:0]   mag_a, mag_b;
    logic [N:0]     shifted;
    logic [N:0]     add_x, add_y;
    logic           add_cin;
    logic [N+1:0]   add_sum;
    logic [N:0]     mul_sum;
    logic           div_ok;
    logic [2*N-1:0] prod, prod_neg;
    logic           b_zero;
    logic [N-1:0]   res_hi, res_lo;

    assign is_div    = op_is_div(op_q);
    assign is_signed = op_is_signed(op_q);

    // Negating the most-negative value yields 2^(N-1), which is exact as an unsigned N-bit magnitude.
    assign mag_a = (is_signed && a_q[N-1]) ? -a_q : a_q;
    assign mag_b = (is_signed && b_q[N-1]) ? -b_q : b_q;

    // Shared adder: acc + multiplicand for multiply, {rem, next dividend bit} - divisor for divide.
    assign shifted = {acc_q, wrk_q[N-1]};
    assign add_x   = is_div ? shifted : {1'b0, acc_q};
    assign add_y   = is_div ? ~{1'b0, opb_q} : {1'b0, opb_q};
    assign add_cin = is_div;
    assign add_sum = {1'b0, add_x} + {1'b0, add_y} + {{(N+1){1'b0}}, add_cin};

    assign mul_sum = wrk_q[0] ? add_sum[N:0] : {1'b0, acc_q};
    assign div_ok  = add_sum[N+1];

    assign prod     = {acc_q, wrk_q};
    assign prod_neg = -prod;
    assign b_zero   = (b_q == '0);

    always_comb begin
        res_hi = acc_q;
        res_lo = wrk_q;
        if (op_q == OP_MULT) begin
            if (a_q[N-1] ^ b_q[N-1]) begin
                {res_hi, res_lo} = prod_neg;
            end
        end else if (is_div) begin
            if (b_zero) begin
                res_hi = a_q;
                res_lo = '1;
            end else if (op_q == OP_DIV) begin
                if (a_q[N-1] ^ b_q[N-1]) begin
                    res_lo = -wrk_q;
                end
                if (a_q[N-1]) begin
                    res_hi = -acc_q;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prep_d  = prep_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        wrk_d   = wrk_q;
        opb_d   = opb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    op_d    = op_e'(op);
                    a_d     = A;
                    b_d     = B;
                    cnt_d   = '0;
                    prep_d  = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            ST_RUN: begin
                if (prep_q) begin
                    prep_d = 1'b0;
                    acc_d  = '0;
                    wrk_d  = mag_a;
                    opb_d  = mag_b;
                end else begin
                    if (is_div) begin
                        acc_d = div_ok ? add_sum[N-1:0] : shifted[N-1:0];
                        wrk_d = {wrk_q[N-2:0], div_ok};
                    end else begin
                        acc_d = mul_sum[N:1];
                        wrk_d = {mul_sum[0], wrk_q[N-1:1]};
                    end
                    if (cnt_q == LAST_IT) begin
                        state_d = ST_FIX;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_FIX: begin
                hi_d    = res_hi;
                lo_d    = res_lo;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            prep_q  <= 1'b0;
            op_q    <= OP_MULT;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            wrk_q   <= '0;
            opb_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prep_q  <= prep_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            wrk_q   <= wrk_d;
            opb_q   <= opb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv.sv
// Self-checking bench for muldiv (N=32): directed vectors, corner sequences, random ops vs a model.
module tb_muldiv;

    localparam int LAT = 34;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op_i;
    logic [31:0] a_i, b_i;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    muldiv #(.N(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op_i),
        .A     (a_i),
        .B     (b_i),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs[NV];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV signed / and % already truncate toward zero.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r, p;
        logic [63:0] u;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'b01: begin
                u = {32'b0, x} * {32'b0, y};
                return u;
            end
            2'b00: begin
                p = sx * sy;
                return p;
            end
            2'b11: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
            default: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    task automatic wait_done(inout int lat);
        bit overlap;
        overlap = 1'b0;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (busy === 1'b1 && done === 1'b1) overlap = 1'b1;
        end
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: done not seen after %0d cycles", lat);
        end
        check("busy_done_overlap", {63'b0, overlap}, 64'd0);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit now, input bit scramble, output int lat);
        if (!now) @(negedge clk);
        op_i  = o;
        a_i   = x;
        b_i   = y;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_accept", {63'b0, busy}, 64'd1);
        if (scramble) begin
            op_i = 2'($urandom);
            a_i  = $urandom;
            b_i  = $urandom;
        end
        lat = 0;
        wait_done(lat);
    endtask

    initial begin
        int lat;
        bit saw;
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        logic [63:0] exp;

        vecs[0]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1]  = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[2]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{2'b11, 32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF};
        vecs[4]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[5]  = '{2'b11, 32'd1000,      32'd3,         32'd1,         32'd333};
        vecs[6]  = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
        vecs[7]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[8]  = '{2'b10, 32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 32'hFFFF_FFFF};
        vecs[9]  = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[10] = '{2'b11, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF};
        vecs[11] = '{2'b01, 32'h1234_5678, 32'd0,         32'd0,         32'd0};
        vecs[12] = '{2'b10, 32'h8000_0000, 32'd7,         32'hFFFF_FFFE, 32'hEDB6_DB6E};

        reset = 1'b1;
        start = 1'b0;
        op_i  = 2'b00;
        a_i   = '0;
        b_i   = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_busy", {63'b0, busy}, 64'd0);
        check("reset_done", {63'b0, done}, 64'd0);
        check("reset_hi", {32'b0, hi}, 64'd0);
        check("reset_lo", {32'b0, lo}, 64'd0);

        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 1'b1, lat);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(LAT));
            check($sformatf("vec%0d_hi", i), {32'b0, hi}, {32'b0, vecs[i].hi});
            check($sformatf("vec%0d_lo", i), {32'b0, lo}, {32'b0, vecs[i].lo});
            check($sformatf("vec%0d_busy_in_done", i), {63'b0, busy}, 64'd0);
        end

        repeat (10) @(posedge clk);
        #1;
        check("hold_done_low", {63'b0, done}, 64'd0);
        check("hold_hi", {32'b0, hi}, {32'b0, vecs[NV-1].hi});
        check("hold_lo", {32'b0, lo}, {32'b0, vecs[NV-1].lo});

        // A start pulse mid-run must not disturb the operation in flight.
        @(negedge clk);
        op_i = 2'b01; a_i = 32'd6; b_i = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        repeat (6) begin @(posedge clk); #1; lat++; end
        op_i = 2'b11; a_i = 32'd99; b_i = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        lat++;
        start = 1'b0;
        wait_done(lat);
        check("ignored_start_latency", 64'(lat), 64'(LAT));
        check("ignored_start_hi", {32'b0, hi}, 64'd0);
        check("ignored_start_lo", {32'b0, lo}, 64'd42);

        // Back-to-back: start raised during the done cycle.
        run_op(2'b11, 32'd1000, 32'd7, 1'b1, 1'b0, lat);
        check("b2b_latency", 64'(lat), 64'(LAT));
        check("b2b_hi", {32'b0, hi}, 64'd6);
        check("b2b_lo", {32'b0, lo}, 64'd142);

        // Reset mid-run aborts with no late done pulse.
        @(negedge clk);
        op_i = 2'b11; a_i = 32'd1000; b_i = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_busy", {63'b0, busy}, 64'd0);
        check("abort_done", {63'b0, done}, 64'd0);
        check("abort_hi", {32'b0, hi}, 64'd0);
        check("abort_lo", {32'b0, lo}, 64'd0);
        saw = 1'b0;
        repeat (60) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) saw = 1'b1;
        end
        check("abort_no_done", {63'b0, saw}, 64'd0);

        run_op(2'b11, 32'd1000, 32'd3, 1'b0, 1'b0, lat);
        check("post_abort_latency", 64'(lat), 64'(LAT));
        check("post_abort_hi", {32'b0, hi}, 64'd1);
        check("post_abort_lo", {32'b0, lo}, 64'd333);

        // Reset wins over start in the same cycle.
        @(negedge clk);
        reset = 1'b1; start = 1'b1; op_i = 2'b01; a_i = 32'd3; b_i = 32'd3;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        check("reset_prio_busy", {63'b0, busy}, 64'd0);
        check("reset_prio_lo", {32'b0, lo}, 64'd0);
        @(posedge clk); #1;
        check("reset_prio_busy_next", {63'b0, busy}, 64'd0);

        for (int i = 0; i < 150; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 9))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            exp = model(ro, ra, rb);
            run_op(ro, ra, rb, 1'b0, 1'b1, lat);
            check($sformatf("rand%0d_op%0d_%h_%h_latency", i, ro, ra, rb), 64'(lat), 64'(LAT));
            check($sformatf("rand%0d_op%0d_%h_%h_result", i, ro, ra, rb), {hi, lo}, exp);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
